sprite_rom_arbiter: RTL and testbench

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_arb_pkg.sv | 12 +
 rtl/sprite_rr_pick.sv | 32 +++
 rtl/sprite_rom_arbiter.sv | 98 +++++++++
 tb/tb_sprite_rom_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sprite_arb_pkg.sv
// sprite_arb_pkg: shared state encoding and default sizes for the sprite ROM arbiter
package sprite_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/sprite_rr_pick.sv
// sprite_rr_pick: combinational round-robin winner search starting after last_winner
module sprite_rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_winner,
  output logic [NUM_REQ-1:0] pick,
  output logic [IW-1:0]      index,
  output logic               any
);
  logic          found;
  logic [IW-1:0] j;
  assign any = |req;
  // walk the ring from last_winner+1; the first set request wins
  always_comb begin
    pick = '0;
    index = '0;
    found = 1'b0;
    j = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IW'((int'(last_winner) + k) % NUM_REQ);
      if (!found && req[j]) begin
        found = 1'b1;
        pick[j] = 1'b1;
        index = j;
      end
    end
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin access to a shared sync sprite ROM; SPRITE_ARB_BLANK_GATE_EN blocks new grants during blank
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic                      blank,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_en,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      busy
);
  localparam int IW = $clog2(NUM_REQ);
  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d, rd_valid_q, rd_valid_d, pick;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                rom_en_q, rom_en_d, any, arb_ok;
  logic [IW-1:0]       last_q, last_d, idx;
`ifdef SPRITE_ARB_BLANK_GATE_EN
  assign arb_ok = ~blank;
`else
  logic unused_blank;
  assign unused_blank = blank;
  assign arb_ok = 1'b1;
`endif
  sprite_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req(req),
    .last_winner(last_q),
    .pick(pick),
    .index(idx),
    .any(any)
  );
  assign gnt = gnt_q;
  assign rd_valid = rd_valid_q;
  assign rd_data = rd_data_q;
  assign rom_addr = rom_addr_q;
  assign rom_en = rom_en_q;
  assign busy = state_q != IDLE;
  // next-state and registered outputs; rom_en/rd_valid are set on entry to ISSUE/DONE
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    rd_valid_d = '0;
    rd_data_d = rd_data_q;
    rom_addr_d = rom_addr_q;
    rom_en_d = 1'b0;
    last_d = last_q;
    unique case (state_q)
      IDLE: if (any && arb_ok) begin
        state_d = ISSUE;
        gnt_d = pick;
        last_d = idx;
        rom_addr_d = addr[idx*ADDR_W +: ADDR_W];
        rom_en_d = 1'b1;
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        rd_data_d = rom_data;
        rd_valid_d = gnt_q;
        state_d = DONE;
      end
      DONE: begin
        gnt_d = '0;
        state_d = IDLE;
      end
    endcase
  end
  // state and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rd_valid_q <= '0;
      rd_data_q <= '0;
      rom_addr_q <= '0;
      rom_en_q <= 1'b0;
      last_q <= IW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
      rom_addr_q <= rom_addr_d;
      rom_en_q <= rom_en_d;
      last_q <= last_d;
    end
  end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: vector table, corner sequences and random traffic against a transaction-level model
module tb_sprite_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] addr = '0;
  logic        blank = 1'b0;
  logic [3:0]  gnt, rd_valid;
  logic [7:0]  rd_data, rom_data;
  logic [15:0] rom_addr;
  logic        rom_en, busy;
  int n_cmp = 0;
  int n_err = 0;
  int e = 0;
  int g = -100;
  int win = 0;
  int last = 3;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_data = '0;

  sprite_rom_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .blank(blank),
    .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [15:0] a);
    return (a == 16'h0123) ? 8'hA5 : (a[7:0] ^ {a[15:9], 1'b1} ^ 8'h3C);
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= rom_fn(rom_addr);

  function automatic int rr(input logic [3:0] r, input int lw);
    for (int k = 1; k <= 4; k++) if (r[(lw + k) % 4]) return (lw + k) % 4;
    return 0;
  endfunction

  function automatic bit arb_ok(input logic b);
`ifdef SPRITE_ARB_BLANK_GATE_EN
    return !b;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // one clock: inputs applied at negedge, model advanced at posedge, outputs checked at next negedge
  task automatic cyc(input logic [3:0] r, input logic b);
    int k;
    req = r;
    blank = b;
    @(posedge clk);
    e++;
    if (e - g >= 4 && |r && arb_ok(b)) begin
      win = rr(r, last);
      last = win;
      g = e;
      m_addr = addr[win*16 +: 16];
    end
    if (e - g == 2) m_data = rom_fn(m_addr);
    @(negedge clk);
    k = e - g;
    chk("gnt", 32'(gnt), (k >= 0 && k <= 2) ? 32'(1 << win) : 32'h0);
    chk("rom_en", 32'(rom_en), 32'(k == 0));
    chk("rom_addr", 32'(rom_addr), 32'(m_addr));
    chk("rd_valid", 32'(rd_valid), (k == 2) ? 32'(1 << win) : 32'h0);
    chk("rd_data", 32'(rd_data), 32'(m_data));
    chk("busy", 32'(busy), 32'(k >= 0 && k <= 2));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_gnt"}, 32'(gnt), 0);
    chk({nm, "_rv"}, 32'(rd_valid), 0);
    chk({nm, "_data"}, 32'(rd_data), 0);
    chk({nm, "_raddr"}, 32'(rom_addr), 0);
    chk({nm, "_ren"}, 32'(rom_en), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    g = -100;
    last = 3;
    win = 0;
    m_addr = '0;
    m_data = '0;
    chk_zero("reset");
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int ord[$];
    int rv_at[$];
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    tbl[0] = '{4'b0001, 4'b0001};
    tbl[1] = '{4'b1111, 4'b0010};
    tbl[2] = '{4'b1010, 4'b1000};
    tbl[3] = '{4'b1010, 4'b0010};
    tbl[4] = '{4'b1111, 4'b0100};
    tbl[5] = '{4'b1001, 4'b1000};
    tbl[6] = '{4'b0110, 4'b0010};
    tbl[7] = '{4'b0001, 4'b0001};
    @(negedge clk);
    do_reset();
    // single read of ROM[0x123]
    addr = 64'h0;
    addr[15:0] = 16'h0123;
    cyc(4'b0001, 1'b0);
    chk("basic_ren", 32'(rom_en), 1);
    chk("basic_raddr", 32'(rom_addr), 32'h0123);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    chk("basic_rv", 32'(rd_valid), 32'b0001);
    chk("basic_data", 32'(rd_data), 32'hA5);
    cyc(4'b0000, 1'b0);
    chk("basic_idle", 32'(busy), 0);
    chk("basic_hold", 32'(rd_data), 32'hA5);
    // round-robin vector table from reset
    do_reset();
    foreach (tbl[i]) begin
      addr = {$urandom, $urandom};
      cyc(tbl[i].req, 1'b0);
      chk("tbl_gnt", 32'(gnt), 32'(tbl[i].gnt));
      cyc(tbl[i].req, 1'b0);
      cyc(tbl[i].req, 1'b0);
      chk("tbl_rv", 32'(rd_valid), 32'(tbl[i].gnt));
      cyc(4'b0000, 1'b0);
    end
    // all four requesting continuously: order 0,1,2,3,0 with 4-cycle spacing
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cyc(4'b1111, 1'b0);
      if (rom_en) ord.push_back($clog2(int'(gnt)));
      if (|rd_valid) rv_at.push_back(c);
    end
    chk("rr_count", 32'(ord.size() >= 5), 1);
    for (int i = 0; i < 5 && i < ord.size(); i++) chk("rr_order", 32'(ord[i]), 32'(exp_ord[i]));
    for (int i = 1; i < rv_at.size(); i++) chk("rv_spacing", 32'(rv_at[i] - rv_at[i-1]), 4);
    // reset during CAPTURE aborts silently, then requester 0 wins first
    do_reset();
    cyc(4'b0001, 1'b0);
    cyc(4'b0001, 1'b0);
    rst = 1'b1;
    #1;
    chk_zero("abort");
    do_reset();
    cyc(4'b1111, 1'b0);
    chk("abort_regrant", 32'(gnt), 32'b0001);
    for (int c = 0; c < 3; c++) cyc(4'b0000, 1'b0);
    // blank handling
    do_reset();
`ifdef SPRITE_ARB_BLANK_GATE_EN
    for (int c = 0; c < 3; c++) begin
      cyc(4'b0100, 1'b1);
      chk("blank_hold", 32'(gnt), 0);
    end
    cyc(4'b0100, 1'b0);
    chk("blank_release", 32'(gnt), 32'b0100);
`else
    cyc(4'b0100, 1'b1);
    chk("blank_ignored", 32'(gnt), 32'b0100);
`endif
    for (int c = 0; c < 3; c++) cyc(4'b0000, 1'b1);
    // req dropped during ISSUE still completes
    do_reset();
    addr[47:32] = 16'h0BEE;
    cyc(4'b0100, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    chk("drop_rv", 32'(rd_valid), 32'b0100);
    chk("drop_data", 32'(rd_data), 32'(rom_fn(16'h0BEE)));
    cyc(4'b0000, 1'b0);
    chk("drop_idle", 32'(busy), 0);
    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) addr = {$urandom, $urandom};
      cyc(4'($urandom), ($urandom_range(0, 4) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
